// File: rtl/disp_arbiter.sv
// Purpose: shares the 4-digit display between three requesters (fixed priority, minimum hold time, per-client blink).
// Latency: all outputs are registered; a grant or an owner value change shows up 1 cycle after it is sampled.
// Backpressure: none; requesters keep req high for as long as they want the screen, and a losing requester simply waits.
module disp_arbiter #(
  parameter int DIV   = 50000,
  parameter int HOLD  = 500,
  parameter int BLINK = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  input  logic [2:0]  blink,
  output logic [2:0]  gnt,
  output logic [3:0]  num3,
  output logic [3:0]  num2,
  output logic [3:0]  num1,
  output logic [3:0]  num0,
  output logic        blank
);

  // Counter widths; a degenerate parameter of 1 still gets a 1-bit counter.
  localparam int PW = (DIV   > 1) ? $clog2(DIV)   : 1;
  localparam int HW = (HOLD  > 1) ? $clog2(HOLD)  : 1;
  localparam int BW = (BLINK > 1) ? $clog2(BLINK) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOCK = 2'd1,
    ST_OPEN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [HW-1:0] hold_q,  hold_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blk_q,   blk_d;
  logic          phase_q, phase_d;
  logic [15:0]   num_q,   num_d;
  logic [2:0]    gnt_q,   gnt_d;
  logic          blank_q, blank_d;

  logic          tick;
  logic          any_req;
  logic [1:0]    hp;
  logic [15:0]   hp_val;
  logic [15:0]   owner_val;
  logic          owner_req;
  logic          higher_req;
  logic          grant;

  // Free-running prescaler; tick marks the last count of each period.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Blink phase flips once every BLINK ticks, independent of ownership.
  always_comb begin
    blk_d   = blk_q;
    phase_d = phase_q;
    if (tick) begin
      if (blk_q == BLINK_LAST) begin
        blk_d   = '0;
        phase_d = ~phase_q;
      end else begin
        blk_d = blk_q + BW'(1);
      end
    end
  end

  // Priority pick (lowest index wins) and the data of the pick and of the current owner.
  always_comb begin
    any_req = |req;
    hp      = 2'd2;
    if (req[0]) begin
      hp = 2'd0;
    end else if (req[1]) begin
      hp = 2'd1;
    end
    case (hp)
      2'd0:    hp_val = val0;
      2'd1:    hp_val = val1;
      default: hp_val = val2;
    endcase
    case (owner_q)
      2'd0:    owner_val = val0;
      2'd1:    owner_val = val1;
      default: owner_val = val2;
    endcase
  end

  // Owner's own request and whether anyone above the owner is asking.
  always_comb begin
    owner_req  = req[owner_q];
    higher_req = 1'b0;
    case (owner_q)
      2'd1:    higher_req = req[0];
      2'd2:    higher_req = req[0] | req[1];
      default: higher_req = 1'b0;
    endcase
  end

  // Ownership FSM: next state, owner, hold count and displayed digits.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    num_d   = num_q;
    grant   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant = any_req;
      end
      ST_LOCK: begin
        // Screen is pinned; a dropped owner request only freezes the digits.
        if (owner_req) begin
          num_d = owner_val;
        end
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_OPEN;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      ST_OPEN: begin
        // Preemption beats release; a release with others waiting hands over to hp.
        if (higher_req || (!owner_req && any_req)) begin
          grant = 1'b1;
        end else if (!owner_req) begin
          state_d = ST_IDLE;
        end else begin
          num_d = owner_val;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (grant) begin
      state_d = ST_LOCK;
      owner_d = hp;
      hold_d  = '0;
      num_d   = hp_val;
    end
  end

  // Output flops are loaded from the next-state values so a grant is visible on its own edge.
  always_comb begin
    gnt_d   = (state_d == ST_IDLE) ? 3'b000 : (3'b001 << owner_d);
    blank_d = (state_d == ST_IDLE) | (blink[owner_d] & phase_d);
  end

  // State and output registers; reset wins over every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      hold_q  <= '0;
      presc_q <= '0;
      blk_q   <= '0;
      phase_q <= 1'b0;
      num_q   <= 16'h0000;
      gnt_q   <= 3'b000;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      presc_q <= presc_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
      num_q   <= num_d;
      gnt_q   <= gnt_d;
      blank_q <= blank_d;
    end
  end

  assign gnt   = gnt_q;
  assign num3  = num_q[15:12];
  assign num2  = num_q[11:8];
  assign num1  = num_q[7:4];
  assign num0  = num_q[3:0];
  assign blank = blank_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Bench for disp_arbiter: vector table, directed multi-cycle sequences, then random traffic against a reference model.
module tb_disp_arbiter;

  localparam int DIV   = 4;
  localparam int HOLD  = 3;
  localparam int BLINK = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [15:0] val0, val1, val2;
  logic [2:0]  blink;
  logic [2:0]  gnt;
  logic [3:0]  num3, num2, num1, num0;
  logic        blank;
  logic [15:0] num_all;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign num_all = {num3, num2, num1, num0};

  disp_arbiter #(.DIV(DIV), .HOLD(HOLD), .BLINK(BLINK)) dut (
    .clk(clk), .rst(rst), .req(req),
    .val0(val0), .val1(val1), .val2(val2), .blink(blink),
    .gnt(gnt), .num3(num3), .num2(num2), .num1(num1), .num0(num0), .blank(blank)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 3'b000;
    step();
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Mode 0 idle, 1 locked, 2 open. Time is counted in non-reset cycles since reset,
  // so the tick and the blink phase are plain arithmetic on that count.
  int          m_mode, m_owner, m_left, m_cyc;
  logic [15:0] m_num;
  logic [2:0]  m_gnt;
  logic        m_blank;

  task automatic model_step();
    logic [15:0] v [3];
    int          hp;
    bit          tick, do_grant, phase;
    v[0] = val0; v[1] = val1; v[2] = val2;
    if (rst) begin
      m_mode = 0; m_owner = 0; m_left = 0; m_cyc = 0; m_num = 16'h0;
    end else begin
      hp = -1;
      for (int i = 2; i >= 0; i--) if (req[i]) hp = i;
      tick     = ((m_cyc % DIV) == DIV - 1);
      do_grant = 1'b0;
      if (m_mode == 0) begin
        do_grant = (hp >= 0);
      end else if (m_mode == 1) begin
        if (req[m_owner]) m_num = v[m_owner];
        if (tick) begin
          m_left--;
          if (m_left == 0) m_mode = 2;
        end
      end else begin
        if (hp >= 0 && (hp < m_owner || !req[m_owner])) do_grant = 1'b1;
        else if (!req[m_owner]) m_mode = 0;
        else m_num = v[m_owner];
      end
      if (do_grant) begin
        m_mode = 1; m_owner = hp; m_left = HOLD; m_num = v[hp];
      end
      m_cyc++;
    end
    phase   = (((m_cyc / DIV) / BLINK) % 2) == 1;
    m_gnt   = (m_mode == 0) ? 3'b000 : 3'(1 << m_owner);
    m_blank = (m_mode == 0) || (blink[m_owner] && phase);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        r;
    logic [2:0]  rq;
    logic [15:0] v0, v1, v2;
    logic [2:0]  bl;
    logic [2:0]  e_gnt;
    logic [15:0] e_num;
    logic        e_blank;
  } vec_t;

  vec_t vt [9];

  initial begin
    int sw, rel, last_t, ntr;
    bit held_ok, frozen_ok, off_ok;
    logic prev;

    vt[0] = '{1'b1, 3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b000, 3'b000, 16'h0000, 1'b1};
    vt[1] = '{1'b1, 3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b000, 3'b000, 16'h0000, 1'b1};
    vt[2] = '{1'b1, 3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b000, 3'b000, 16'h0000, 1'b1};
    vt[3] = '{1'b0, 3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b000, 3'b001, 16'h1111, 1'b0};
    vt[4] = '{1'b1, 3'b000, 16'h1111, 16'h2222, 16'h3333, 3'b000, 3'b000, 16'h0000, 1'b1};
    vt[5] = '{1'b0, 3'b100, 16'h1111, 16'h2222, 16'h1234, 3'b000, 3'b100, 16'h1234, 1'b0};
    vt[6] = '{1'b0, 3'b100, 16'h1111, 16'h2222, 16'hABCD, 3'b000, 3'b100, 16'hABCD, 1'b0};
    vt[7] = '{1'b0, 3'b100, 16'h1111, 16'h2222, 16'hABCD, 3'b000, 3'b100, 16'hABCD, 1'b0};
    vt[8] = '{1'b0, 3'b000, 16'h1111, 16'h2222, 16'h9999, 3'b000, 3'b100, 16'hABCD, 1'b0};

    rst = 1'b1; req = 3'b111; blink = 3'b000;
    val0 = 16'h1111; val1 = 16'h2222; val2 = 16'h3333;
    #1;

    for (int i = 0; i < 9; i++) begin
      rst = vt[i].r; req = vt[i].rq; blink = vt[i].bl;
      val0 = vt[i].v0; val1 = vt[i].v1; val2 = vt[i].v2;
      step();
      chk($sformatf("vec%0d_gnt", i), gnt, vt[i].e_gnt);
      chk($sformatf("vec%0d_num", i), num_all, vt[i].e_num);
      chk($sformatf("vec%0d_blank", i), blank, vt[i].e_blank);
    end

    // Locked preemption: client 0 asks one cycle after client 2 is granted.
    do_reset();
    blink = 3'b000; val0 = 16'h0EEE; val2 = 16'h2222; req = 3'b100;
    step();
    chk("pre_grant", gnt, 3'b100);
    req = 3'b101; held_ok = 1'b1; sw = 0;
    for (int c = 1; c <= 20 && sw == 0; c++) begin
      step();
      if (gnt === 3'b001) sw = c;
      else if (gnt !== 3'b100) held_ok = 1'b0;
    end
    chk("pre_held", held_ok, 1);
    chk("pre_switch_cycle", sw, 12);
    chk("pre_num", num_all, 16'h0EEE);
    chk("pre_blank", blank, 1'b0);

    // Release during lock: digits freeze, display released only once open.
    do_reset();
    val1 = 16'h5678; req = 3'b010;
    step();
    chk("rel_grant", gnt, 3'b010);
    chk("rel_num", num_all, 16'h5678);
    req = 3'b000; val1 = 16'h1111; frozen_ok = 1'b1; rel = 0;
    for (int c = 1; c <= 20 && rel == 0; c++) begin
      step();
      if (gnt === 3'b000) rel = c;
      else if (num_all !== 16'h5678 || blank !== 1'b0 || gnt !== 3'b010) frozen_ok = 1'b0;
    end
    chk("rel_frozen", frozen_ok, 1);
    chk("rel_cycle", rel, 12);
    chk("rel_blank", blank, 1'b1);

    // Blink: 8-cycle half period; the first flip comes after 7 cycles from the post-reset grant.
    do_reset();
    blink = 3'b100; val2 = 16'h3333; req = 3'b100;
    step();
    chk("blink_start", blank, 1'b0);
    prev = blank; last_t = 0; ntr = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (blank !== prev) begin
        if (ntr == 0) chk("blink_first", c, 7);
        else chk($sformatf("blink_int%0d", ntr), c - last_t, 8);
        last_t = c; ntr++; prev = blank;
      end
    end
    chk("blink_count", ntr, 5);
    blink = 3'b000; off_ok = 1'b1;
    for (int c = 0; c < 16; c++) begin
      step();
      if (blank !== 1'b0) off_ok = 1'b0;
    end
    chk("blink_off", off_ok, 1);

    // Reset in the middle of a lock restarts hold and prescaler.
    do_reset();
    val0 = 16'h4321; val1 = 16'h7777; req = 3'b001;
    step();
    chk("mid_grant", gnt, 3'b001);
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("mid_rst_gnt", gnt, 3'b000);
    chk("mid_rst_num", num_all, 16'h0000);
    chk("mid_rst_blank", blank, 1'b1);
    rst = 1'b0;
    step();
    chk("mid_regrant", gnt, 3'b001);
    chk("mid_regrant_num", num_all, 16'h4321);
    req = 3'b010; sw = 0;
    for (int c = 1; c <= 20 && sw == 0; c++) begin
      step();
      if (gnt === 3'b010) sw = c;
    end
    chk("mid_handover_cycle", sw, 12);

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      rst = (n == 0) || ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) val0 = 16'($urandom);
      if ($urandom_range(0, 1) == 0) val1 = 16'($urandom);
      if ($urandom_range(0, 1) == 0) val2 = 16'($urandom);
      if ($urandom_range(0, 15) == 0) blink = 3'($urandom_range(0, 7));
      model_step();
      step();
      chk($sformatf("rnd%0d_gnt", n), gnt, m_gnt);
      chk($sformatf("rnd%0d_num", n), num_all, m_num);
      chk($sformatf("rnd%0d_blank", n), blank, m_blank);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
